// File: rtl/datapath_seq_if.sv
// datapath_seq_if: host command, datapath drive and result FIFO signals of the sequencer.
interface datapath_seq_if #(parameter int FIFO_DEPTH = 4);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [7:0]                    cmd_a;
  logic [7:0]                    cmd_b;
  logic [3:0]                    cmd_c;
  logic [3:0]                    cmd_d;
  logic [1:0]                    cmd_sel;
  logic                          dp_start;
  logic [7:0]                    dp_a;
  logic [7:0]                    dp_b;
  logic [3:0]                    dp_c;
  logic [3:0]                    dp_d;
  logic [1:0]                    dp_sel;
  logic                          dp_ready;
  logic [7:0]                    dp_result;
  logic                          res_valid;
  logic                          res_ready;
  logic [7:0]                    res_data;
  logic [$clog2(FIFO_DEPTH):0]   res_count;
  logic                          busy;
  logic                          err_timeout;
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_c, cmd_d, cmd_sel, dp_ready, dp_result, res_ready,
    output cmd_ready, dp_start, dp_a, dp_b, dp_c, dp_d, dp_sel, res_valid, res_data, res_count,
           busy, err_timeout
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_c, cmd_d, cmd_sel, dp_ready, dp_result, res_ready,
    input  cmd_ready, dp_start, dp_a, dp_b, dp_c, dp_d, dp_sel, res_valid, res_data, res_count,
           busy, err_timeout
  );
endinterface

// File: rtl/datapath_seq.sv
// datapath_seq: issues host commands to the datapath and queues results in a FIFO; DATAPATH_SEQ_TIMEOUT_EN adds a dp_ready timeout.
module datapath_seq #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input logic           clk,
  input logic           rst,
  datapath_seq_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_a, r_b, r_res;
  logic [3:0]    r_c, r_d;
  logic [1:0]    r_sel;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_cmd_ready, w_acc, w_cap, w_push, w_pop, w_to;
`ifdef DATAPATH_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wait;
  logic          r_err;
  // counter holds k-1 in the k-th WAIT cycle, so the limit hits on WAIT cycle TIMEOUT_CYC
  assign w_to = r_state == WAIT && !bus.dp_ready && r_wait == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wait <= r_state == WAIT ? r_wait + 1'b1 : '0;
      if (w_to) r_err <= 1'b1;
    end
  end
  assign bus.err_timeout = r_err;
`else
  assign w_to            = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif
  always_comb begin
    w_cmd_ready = r_state == IDLE && r_cnt < CW'(FIFO_DEPTH);
    w_acc       = w_cmd_ready && bus.cmd_valid;
    w_cap       = r_state == WAIT && (bus.dp_ready || w_to);
    w_push      = r_state == STORE;
    w_pop       = r_cnt != '0 && bus.res_ready;
    w_next      = r_state == IDLE  ? (w_acc ? ISSUE : IDLE)
                : r_state == ISSUE ? WAIT
                : r_state == WAIT  ? (w_cap ? STORE : WAIT)
                : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_sel   <= '0;
      r_res   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_a   <= bus.cmd_a;
        r_b   <= bus.cmd_b;
        r_c   <= bus.cmd_c;
        r_d   <= bus.cmd_d;
        r_sel <= bus.cmd_sel;
      end
      if (w_cap) r_res <= bus.dp_ready ? bus.dp_result : 8'hFF;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  // storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= r_res;
  end
  assign bus.cmd_ready = w_cmd_ready;
  assign bus.dp_start  = r_state == ISSUE;
  assign bus.dp_a      = r_a;
  assign bus.dp_b      = r_b;
  assign bus.dp_c      = r_c;
  assign bus.dp_d      = r_d;
  assign bus.dp_sel    = r_sel;
  assign bus.res_valid = r_cnt != '0;
  assign bus.res_data  = r_mem[r_rp];
  assign bus.res_count = r_cnt;
  assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: scoreboard bench with a behavioural datapath that answers a fixed number of cycles after dp_start.
module tb_datapath_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  datapath_seq_if #(.FIFO_DEPTH(4)) bus();
  datapath_seq #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int mode  = 0;
  int dly   = 2;
  logic [7:0] exp_q[$];
  function automatic logic [7:0] model_res(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    return mode == 1 ? {s, 6'h00} : a ^ b;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // datapath model: answers in the dly-th WAIT cycle; dly=0 never answers
  initial begin
    logic [7:0] ma, mb;
    logic [1:0] ms;
    bus.dp_ready  = 1'b0;
    bus.dp_result = 8'h00;
    forever begin
      tick();
      if (bus.dp_start === 1'b1 && dly != 0) begin
        ma = bus.dp_a;
        mb = bus.dp_b;
        ms = bus.dp_sel;
        repeat (dly) tick();
        bus.dp_ready  = 1'b1;
        bus.dp_result = model_res(ma, mb, ms);
        tick();
        bus.dp_ready  = 1'b0;
      end
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                      input logic [3:0] d, input logic [1:0] s);
    int n = 0;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_c = c; bus.cmd_d = d; bus.cmd_sel = s;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
    tests++;
    if (n == 200) begin fails++; $display("FAIL send_accept: cmd_ready=%b required 1", bus.cmd_ready); end
    else exp_q.push_back(model_res(a, b, s));
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.res_ready = 1'b0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_c = '0; bus.cmd_d = '0; bus.cmd_sel = '0;
    rst = 1'b1;
    repeat (3) tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    tests++; if (bus.res_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.res_count); end
    tests++; if (bus.dp_start !== 1'b0) begin fails++; $display("FAIL reset_dp_start: got %b want 0", bus.dp_start); end
    tests++; if ({bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_d, bus.dp_sel} !== 26'd0) begin
      fails++; $display("FAIL reset_operands: got %h want 0", {bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_d, bus.dp_sel}); end
    tests++; if (bus.err_timeout !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err_timeout); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_single();
    int n = 0;
    mode = 0; dly = 2;
    send(8'hA5, 8'h61, 4'hA, 4'h6, 2'b00);
    tests++; if (bus.dp_start !== 1'b1) begin fails++; $display("FAIL single_start_hi: got %b want 1", bus.dp_start); end
    tests++; if ({bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_d, bus.dp_sel} !== {8'hA5, 8'h61, 4'hA, 4'h6, 2'b00}) begin
      fails++; $display("FAIL single_operands: got %h want %h", {bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_d, bus.dp_sel},
                        {8'hA5, 8'h61, 4'hA, 4'h6, 2'b00}); end
    tick();
    tests++; if (bus.dp_start !== 1'b0) begin fails++; $display("FAIL single_start_lo: got %b want 0", bus.dp_start); end
    while (bus.res_valid !== 1'b1 && n < 20) begin tick(); n++; end
    tests++; if (n != 3) begin fails++; $display("FAIL single_latency: got %0d want 3", n); end
    tests++; if (bus.res_data !== 8'hC4) begin fails++; $display("FAIL single_data: got %h want c4", bus.res_data); end
    tests++; if (bus.res_count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d want 1", bus.res_count); end
    bus.res_ready = 1'b1;
    void'(exp_q.pop_front());
    tick();
    bus.res_ready = 1'b0;
    tests++; if (bus.res_count !== 3'd0) begin fails++; $display("FAIL single_pop: got %0d want 0", bus.res_count); end
  endtask
  task automatic test_back_to_back();
    int n = 0;
    mode = 1; dly = 2; bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i * 3), 8'h11, 4'(i), 4'h0, 2'(i));
    while (bus.res_count !== 3'd4 && n < 20) begin tick(); n++; end
    tests++; if (bus.res_count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d want 4", bus.res_count); end
    repeat (3) tick();
    tests++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL fill_cmd_ready: got %b want 0", bus.cmd_ready); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL fill_busy: got %b want 0", bus.busy); end
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.res_valid !== 1'b1 || exp_q.size() == 0 || bus.res_data !== exp_q[0]) begin
        fails++; $display("FAIL fill_order[%0d]: got %h valid %b want %h", i, bus.res_data, bus.res_valid,
                          exp_q.size() ? exp_q[0] : 8'hxx); end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      tick();
    end
    bus.res_ready = 1'b0;
    tests++; if (bus.res_count !== 3'd0) begin fails++; $display("FAIL fill_drain: got %0d want 0", bus.res_count); end
  endtask
  task automatic test_simul_push_pop();
    int n = 0;
    mode = 1; dly = 2; bus.res_ready = 1'b0;
    for (int i = 1; i < 4; i++) send(8'h00, 8'h00, 4'h0, 4'h0, 2'(i));
    while (bus.res_count !== 3'd3 && n < 20) begin tick(); n++; end
    send(8'h00, 8'h00, 4'h0, 4'h0, 2'b00);
    repeat (3) tick();
    tests++; if (bus.res_count !== 3'd3) begin fails++; $display("FAIL simul_pre: got %0d want 3", bus.res_count); end
    tests++; if (bus.res_data !== exp_q[0]) begin fails++; $display("FAIL simul_head: got %h want %h", bus.res_data, exp_q[0]); end
    void'(exp_q.pop_front());
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    tests++; if (bus.res_count !== 3'd3) begin fails++; $display("FAIL simul_count: got %0d want 3", bus.res_count); end
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.res_valid !== 1'b1 || exp_q.size() == 0 || bus.res_data !== exp_q[0]) begin
        fails++; $display("FAIL simul_order[%0d]: got %h valid %b want %h", i, bus.res_data, bus.res_valid,
                          exp_q.size() ? exp_q[0] : 8'hxx); end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      tick();
    end
    bus.res_ready = 1'b0;
  endtask
  task automatic test_wrap();
    int got = 0;
    mode = 0; dly = 2;
    fork
      for (int i = 0; i < 10; i++) send(8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
      begin
        int cyc = 0;
        while (got < 10 && cyc < 600) begin
          bus.res_ready = 1'($urandom_range(0, 1));
          if (bus.res_valid === 1'b1 && bus.res_ready) begin
            tests++;
            if (exp_q.size() == 0 || bus.res_data !== exp_q[0]) begin
              fails++; $display("FAIL wrap_data[%0d]: got %h want %h", got, bus.res_data, exp_q.size() ? exp_q[0] : 8'hxx); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
          end
          tick();
          cyc++;
        end
      end
    join
    bus.res_ready = 1'b0;
    tests++; if (got != 10) begin fails++; $display("FAIL wrap_received: got %0d want 10", got); end
    repeat (5) tick();
    tests++; if (bus.res_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL wrap_leftover: res_valid %b pending %0d want 0 0", bus.res_valid, exp_q.size()); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    mode = 0; dly = 2; bus.res_ready = 1'b0;
    send(8'h12, 8'h34, 4'h1, 4'h2, 2'b01);
    while (bus.res_valid !== 1'b1 && n < 20) begin tick(); n++; end
    dly = 4;
    send(8'h5A, 8'hC3, 4'h7, 4'h9, 2'b10);
    tick();
    rst = 1'b1;
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL rstmid_res_valid: got %b want 0", bus.res_valid); end
    tests++; if (bus.dp_start !== 1'b0) begin fails++; $display("FAIL rstmid_dp_start: got %b want 0", bus.dp_start); end
    tests++; if ({bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_d, bus.dp_sel} !== 26'd0) begin
      fails++; $display("FAIL rstmid_operands: got %h want 0", {bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_d, bus.dp_sel}); end
    rst = 1'b0;
    exp_q.delete();
    repeat (8) tick();
    tests++; if (bus.busy !== 1'b0 || bus.res_count !== 3'd0) begin
      fails++; $display("FAIL rstmid_late_ready: busy %b count %0d want 0 0", bus.busy, bus.res_count); end
  endtask
`ifdef DATAPATH_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    mode = 0; dly = 0; bus.res_ready = 1'b0;
    send(8'h01, 8'h02, 4'h0, 4'h0, 2'b00);
    exp_q.delete();
    repeat (16) tick();
    tests++; if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL to_early: err %b busy %b want 0 1", bus.err_timeout, bus.busy); end
    tick();
    tests++; if (bus.err_timeout !== 1'b1) begin fails++; $display("FAIL to_flag: got %b want 1", bus.err_timeout); end
    tick();
    tests++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'hFF) begin
      fails++; $display("FAIL to_data: valid %b data %h want 1 ff", bus.res_valid, bus.res_data); end
    do_reset();
    dly = 16;
    send(8'h3C, 8'h0F, 4'h0, 4'h0, 2'b00);
    repeat (18) tick();
    tests++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp_q[0]) begin
      fails++; $display("FAIL to_tie_data: valid %b data %h want 1 %h", bus.res_valid, bus.res_data, exp_q[0]); end
    tests++; if (bus.err_timeout !== 1'b0) begin fails++; $display("FAIL to_tie_err: got %b want 0", bus.err_timeout); end
    do_reset();
  endtask
`else
  task automatic test_stall();
    logic all_busy = 1'b1;
    mode = 0; dly = 0; bus.res_ready = 1'b0;
    send(8'h01, 8'h02, 4'h0, 4'h0, 2'b00);
    for (int i = 0; i < 100; i++) begin
      tick();
      all_busy &= bus.busy;
    end
    tests++; if (all_busy !== 1'b1) begin fails++; $display("FAIL stall_busy: got %b want 1", all_busy); end
    tests++; if (bus.err_timeout !== 1'b0 || bus.res_valid !== 1'b0) begin
      fails++; $display("FAIL stall_err: err %b valid %b want 0 0", bus.err_timeout, bus.res_valid); end
    do_reset();
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_simul_push_pop();
    test_wrap();
    test_reset_mid();
`ifdef DATAPATH_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Initiator-side controller for the lab datapath. It accepts operand/opcode commands from an upstream host over valid/ready and drives the datapath's start/a/b/c/d/sel inputs.
- It waits for the datapath's ready, then captures the 8-bit result into an internal result FIFO. The FIFO is drained downstream over valid/ready.
- Replaces the hand-written stimulus loop with a reusable synthesizable issuer.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.
- TIMEOUT_CYC, 16, cycles to wait for dp_ready before abort (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  8  operand a.
- cmd_b  in  8  operand b.
- cmd_c  in  4  operand c.
- cmd_d  in  4  operand d.
- cmd_sel  in  2  datapath opcode.
- dp_start  out  1  start strobe to datapath.
- dp_a  out  8  registered operand a to datapath.
- dp_b  out  8  registered operand b to datapath.
- dp_c  out  4  registered operand c to datapath.
- dp_d  out  4  registered operand d to datapath.
- dp_sel  out  2  registered opcode to datapath.
- dp_ready  in  1  datapath result valid.
- dp_result  in  8  datapath result.
- res_valid  out  1  FIFO non-empty.
- res_ready  in  1  downstream pop.
- res_data  out  8  FIFO head; valid only while res_valid=1.
- res_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky timeout flag; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset values: all outputs 0; dp_* operand registers 0; FIFO empty; state IDLE.
- Reset (rst=1) sampled mid-operation aborts immediately. Any in-flight op is dropped and FIFO contents are discarded.
- FSM states: IDLE, ISSUE, WAIT, STORE.
- IDLE:
  - cmd_ready = 1 iff FIFO has at least one free slot, counting the slot reserved for the pending result.
  - On cmd_valid && cmd_ready: latch operands into dp_a..dp_sel, go to ISSUE.
- ISSUE: dp_start = 1 for exactly one cycle; next state WAIT.
- WAIT:
  - dp_start = 0.
  - On the first cycle with dp_ready = 1, register dp_result and go to STORE.
  - Minimum command-to-capture latency is 3 cycles (accept, ISSUE, WAIT).
  - dp_ready asserted during ISSUE is ignored.
- STORE: push the captured result into the FIFO, go to IDLE. Throughput is at most one command per 4 cycles.
- Operand registers hold their value from accept until the next accept. The datapath may sample them at any point during WAIT.
- cmd_ready = 0 in every state other than IDLE.
- FIFO:
  - Circular buffer with wrapping read and write pointers.
  - res_data is driven from the head entry (combinational read).
  - Pop occurs when res_valid && res_ready.
  - A push in STORE is guaranteed to have space, because space was reserved at accept.
  - Simultaneous push and pop in one cycle leaves res_count unchanged; the data order is preserved.
  - Pop when empty is ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: DATAPATH_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each cycle in WAIT.
  - If the counter reaches TIMEOUT_CYC with dp_ready still 0, set err_timeout (sticky until rst).
  - Push 8'hFF as the result, then go to STORE so the host sees one response per command.
  - dp_ready in the same cycle as the limit wins: the real result is stored and no error is flagged.
- Undefined: no counter; WAIT waits indefinitely; err_timeout tied to 0.

Test Plan:
- Bench datapath model returns a^b three cycles after start. Command a=0xA5, b=0x61, c=0xA, d=0x6, sel=00 -> single-cycle dp_start; res_valid rises with res_data=0xC4; res_count=1.
- Four back-to-back commands with sel=00..11, model returns {sel,6'h0}, res_ready=0 -> res_count reaches 4 and cmd_ready stays 0 (FIFO_DEPTH=4). Then pop with res_ready=1 -> data in order 0x00, 0x40, 0x80, 0xC0.
- FIFO at 3 entries, res_ready=1 in the STORE cycle -> res_count stays 3. Pointer wrap is exercised over 10 commands with no lost or duplicated results.
- Assert rst during WAIT -> next cycle busy=0, res_valid=0, dp_start=0, and all dp_* outputs = 0. A later dp_ready is ignored.
- Timeout test (DATAPATH_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16), model never asserts dp_ready -> after 16 WAIT cycles err_timeout=1 and res_data=0xFF. Second variant: dp_ready asserted exactly on cycle 16 -> real result stored and err_timeout=0.
- Same stall test with the macro undefined -> busy stays 1 for 100 cycles and err_timeout=0.
